// File: rtl/qs_mem_arb_pkg.sv
// Shared types and constants for the per-bank memory port arbiter.
package qs_mem_arb_pkg;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 16;
   localparam int N_MEM_REQ = 3;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] w_t;

   // Requester index: bit position in req_vld / req_gnt / rd_vld_r
   typedef enum logic [1:0] {
      ENQ  = 2'd0,
      SORT = 2'd1,
      DEQ  = 2'd2
   } req_id_t;

   typedef struct packed {
      logic  wen;
      addr_t addr;
      w_t    wdata;
   } mem_req_t;

   // Round-robin pointer after a grant: the winner drops to lowest priority.
   // With no grant the pointer is returned unchanged.
   function automatic logic [1:0] rr_ptr_after(input logic [2:0] gnt,
                                               input logic [1:0] ptr);
      logic [1:0] nxt;
      case (gnt)
         3'b001:  nxt = 2'd1;
         3'b010:  nxt = 2'd2;
         3'b100:  nxt = 2'd0;
         default: nxt = ptr;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/qs_mem_arb_if.sv
// Requester, SRAM and read-return bundle between the arbiter and its users.
interface qs_mem_arb_if;
   import qs_mem_arb_pkg::*;

   logic  [N_MEM_REQ-1:0]        req_vld;
   logic  [N_MEM_REQ-1:0]        req_wen;
   addr_t [N_MEM_REQ-1:0]        req_addr;
   w_t    [N_MEM_REQ-1:0]        req_wdata;
   logic  [N_MEM_REQ-1:0]        req_gnt;
   logic                         sort_lock;
   logic                         mem_en_r;
   logic                         mem_wen_r;
   addr_t                        mem_addr_r;
   w_t                           mem_wdata_r;
   w_t                           mem_rdata;
   logic  [N_MEM_REQ-1:0]        rd_vld_r;
   w_t                           rd_data_r;

   // Engines plus SRAM macro side
   modport master (
      output req_vld, req_wen, req_addr, req_wdata, sort_lock, mem_rdata,
      input  req_gnt, mem_en_r, mem_wen_r, mem_addr_r, mem_wdata_r,
             rd_vld_r, rd_data_r
   );

   // Arbiter side
   modport slave (
      input  req_vld, req_wen, req_addr, req_wdata, sort_lock, mem_rdata,
      output req_gnt, mem_en_r, mem_wen_r, mem_addr_r, mem_wdata_r,
             rd_vld_r, rd_data_r
   );

endinterface

// File: rtl/qs_mem_arb_rr_arb3.sv
// 3-way round-robin arbiter with a hold input that restricts grants to SORT
// and freezes the priority pointer.
module qs_rr_arb3
   import qs_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] i_vld,
   input  logic       i_hold,
   output logic [2:0] o_gnt
);

   logic [1:0] r_ptr;
   logic [1:0] w_ptr_nxt;
   logic [2:0] w_gnt;

   // Priority pointer register; ENQ has top priority out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= 2'd0;
      end else begin
         r_ptr <= w_ptr_nxt;
      end
   end

   // Grant the first valid requester searching upward from r_ptr, mod 3
   always_comb begin
      w_gnt = 3'b000;
      if (i_hold) begin
         w_gnt = {1'b0, i_vld[1], 1'b0};
      end else begin
         case (r_ptr)
            2'd1: begin
               if      (i_vld[1]) w_gnt = 3'b010;
               else if (i_vld[2]) w_gnt = 3'b100;
               else if (i_vld[0]) w_gnt = 3'b001;
               else               w_gnt = 3'b000;
            end
            2'd2: begin
               if      (i_vld[2]) w_gnt = 3'b100;
               else if (i_vld[0]) w_gnt = 3'b001;
               else if (i_vld[1]) w_gnt = 3'b010;
               else               w_gnt = 3'b000;
            end
            default: begin
               if      (i_vld[0]) w_gnt = 3'b001;
               else if (i_vld[1]) w_gnt = 3'b010;
               else if (i_vld[2]) w_gnt = 3'b100;
               else               w_gnt = 3'b000;
            end
         endcase
      end
   end

   // Pointer advances past the winner only when the lock is not held
   always_comb begin
      w_ptr_nxt = r_ptr;
      if (i_hold) begin
         w_ptr_nxt = r_ptr;
      end else begin
         w_ptr_nxt = rr_ptr_after(w_gnt, r_ptr);
      end
   end

   assign o_gnt = w_gnt;

endmodule

// File: rtl/qs_mem_arb.sv
// Per-bank SRAM port arbiter: one grant per cycle, registered SRAM command,
// and a one-hot tag pipe that steers read data back to its requester.
module qs_mem_arb
   import qs_mem_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   qs_mem_arb_if.slave  bus
);

   logic [N_MEM_REQ-1:0] w_gnt;
   logic                 w_acc;
   mem_req_t             w_sel;
   logic [N_MEM_REQ-1:0] w_tag_in;

   logic                 r_mem_en;
   logic                 r_mem_wen;
   addr_t                r_mem_addr;
   w_t                   r_mem_wdata;
   logic [N_MEM_REQ-1:0] r_tag [RD_LAT+1];
   logic [N_MEM_REQ-1:0] r_rd_vld;
   w_t                   r_rd_data;

   qs_rr_arb3 u_arb (
      .clk    (clk),
      .rst    (rst),
      .i_vld  (bus.req_vld),
      .i_hold (bus.sort_lock),
      .o_gnt  (w_gnt)
   );

   assign w_acc = |w_gnt;

   // Select the winning requester's command fields
   always_comb begin
      w_sel = '0;
      case (w_gnt)
         3'b001:  w_sel = mem_req_t'{wen: bus.req_wen[0], addr: bus.req_addr[0], wdata: bus.req_wdata[0]};
         3'b010:  w_sel = mem_req_t'{wen: bus.req_wen[1], addr: bus.req_addr[1], wdata: bus.req_wdata[1]};
         3'b100:  w_sel = mem_req_t'{wen: bus.req_wen[2], addr: bus.req_addr[2], wdata: bus.req_wdata[2]};
         default: w_sel = '0;
      endcase
   end

   // Reads carry the one-hot grant as their return tag; writes carry none
   assign w_tag_in = (w_acc && !w_sel.wen) ? w_gnt : 3'b000;

   // SRAM enable and write-enable, one cycle per accepted request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_en  <= 1'b0;
         r_mem_wen <= 1'b0;
      end else begin
         r_mem_en  <= w_acc;
         r_mem_wen <= w_acc & w_sel.wen;
      end
   end

   // SRAM address and write data, only meaningful alongside r_mem_en
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_mem_addr  <= w_sel.addr;
         r_mem_wdata <= w_sel.wdata;
      end
   end

   // Tag pipe: stage k lines up with the SRAM access k cycles after enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= RD_LAT; i++) begin
            r_tag[i] <= 3'b000;
         end
         r_rd_vld <= 3'b000;
      end else begin
         r_tag[0] <= w_tag_in;
         for (int i = 1; i <= RD_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
         r_rd_vld <= r_tag[RD_LAT];
      end
   end

   // Capture SRAM read data only when a read tag sits at the data stage
   always_ff @(posedge clk) begin
      if (|r_tag[RD_LAT]) begin
         r_rd_data <= bus.mem_rdata;
      end
   end

   assign bus.req_gnt     = w_gnt;
   assign bus.mem_en_r    = r_mem_en;
   assign bus.mem_wen_r   = r_mem_wen;
   assign bus.mem_addr_r  = r_mem_addr;
   assign bus.mem_wdata_r = r_mem_wdata;
   assign bus.rd_vld_r    = r_rd_vld;
   assign bus.rd_data_r   = r_rd_data;

endmodule

// File: tb/tb_qs_mem_arb.sv
// Bench for qs_mem_arb: three instances (RD_LAT 1, 2, 4) share one request
// stream; a reference model predicts grants, SRAM commands and read returns.
module tb_qs_mem_arb;
   import qs_mem_arb_pkg::*;

   localparam int NDUT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic  [2:0] t_vld;
   logic  [2:0] t_wen;
   addr_t [2:0] t_addr;
   w_t    [2:0] t_wdata;
   logic        t_lock;

   logic  [2:0] g_gnt  [NDUT];
   logic        g_men  [NDUT];
   logic        g_mwen [NDUT];
   addr_t       g_maddr[NDUT];
   w_t          g_mwd  [NDUT];
   logic  [2:0] g_rdv  [NDUT];
   w_t          g_rdd  [NDUT];

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
   endfunction

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      localparam int L = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
      qs_mem_arb_if u_if ();
      w_t sram  [256];
      w_t rpipe [4];

      assign u_if.req_vld   = t_vld;
      assign u_if.req_wen   = t_wen;
      assign u_if.req_addr  = t_addr;
      assign u_if.req_wdata = t_wdata;
      assign u_if.sort_lock = t_lock;
      assign u_if.mem_rdata = rpipe[L-1];

      qs_mem_arb #(.RD_LAT(L)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (u_if.slave)
      );

      // SRAM macro model with L-cycle read latency
      always @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < 256; i++) sram[i] <= '0;
            for (int i = 0; i < 4; i++) rpipe[i] <= '0;
         end else begin
            if (u_if.mem_en_r && u_if.mem_wen_r) sram[u_if.mem_addr_r] <= u_if.mem_wdata_r;
            rpipe[0] <= (u_if.mem_en_r && !u_if.mem_wen_r) ? sram[u_if.mem_addr_r] : '0;
            for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
         end
      end

      assign g_gnt[k]   = u_if.req_gnt;
      assign g_men[k]   = u_if.mem_en_r;
      assign g_mwen[k]  = u_if.mem_wen_r;
      assign g_maddr[k] = u_if.mem_addr_r;
      assign g_mwd[k]   = u_if.mem_wdata_r;
      assign g_rdv[k]   = u_if.rd_vld_r;
      assign g_rdd[k]   = u_if.rd_data_r;
   end

   // Reference model state
   typedef struct {
      int         due;
      logic [2:0] tag;
      w_t         data;
   } ret_t;

   int         n_cmp;
   int         n_err;
   int         cyc;
   int         m_ptr;
   w_t         m_mem [256];
   logic [2:0] m_last_gnt;
   logic [2:0] obs_gnt;
   logic       p_en;
   logic       p_wen;
   addr_t      p_addr;
   w_t         p_wdata;
   ret_t       exp_q [NDUT][$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s @cyc %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, expv);
      end
   endtask

   // Grant rule: lock restricts to SORT; otherwise first valid from ptr, mod 3
   function automatic logic [2:0] model_gnt(input logic [2:0] vld, input logic lock, input int ptr);
      if (lock) return vld[1] ? 3'b010 : 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (vld[(ptr + i) % 3]) return 3'b001 << ((ptr + i) % 3);
      end
      return 3'b000;
   endfunction

   task automatic check_regs();
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("mem_en d%0d", k), 32'(g_men[k]), 32'(p_en));
         if (p_en) begin
            chk($sformatf("mem_wen d%0d", k), 32'(g_mwen[k]), 32'(p_wen));
            chk($sformatf("mem_addr d%0d", k), 32'(g_maddr[k]), 32'(p_addr));
            if (p_wen) chk($sformatf("mem_wdata d%0d", k), 32'(g_mwd[k]), 32'(p_wdata));
         end
         if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
            chk($sformatf("rd_vld d%0d", k), 32'(g_rdv[k]), 32'(exp_q[k][0].tag));
            chk($sformatf("rd_data d%0d", k), 32'(g_rdd[k]), 32'(exp_q[k][0].data));
            void'(exp_q[k].pop_front());
         end else begin
            chk($sformatf("rd_idle d%0d", k), 32'(g_rdv[k]), 32'd0);
         end
      end
   endtask

   // One clock cycle: inputs already applied at the preceding negedge
   task automatic cycle();
      logic [2:0] mg;
      int         r;
      #1;
      mg = model_gnt(t_vld, t_lock, m_ptr);
      obs_gnt = g_gnt[0];
      for (int k = 0; k < NDUT; k++) chk($sformatf("gnt d%0d", k), 32'(g_gnt[k]), 32'(mg));
      m_last_gnt = mg;
      p_en = (mg != 3'b000);
      if (p_en) begin
         r = (mg == 3'b001) ? 0 : ((mg == 3'b010) ? 1 : 2);
         if (!t_lock) m_ptr = (r + 1) % 3;
         p_wen   = t_wen[r];
         p_addr  = t_addr[r];
         p_wdata = t_wdata[r];
         if (p_wen) begin
            m_mem[p_addr] = p_wdata;
         end else begin
            for (int k = 0; k < NDUT; k++)
               exp_q[k].push_back(ret_t'{due: cyc + 2 + lat_of(k), tag: mg, data: m_mem[p_addr]});
         end
      end
      @(negedge clk);
      cyc++;
      check_regs();
   endtask

   // Reset for one cycle; called at a negedge
   task automatic do_reset();
      rst = 1'b1;
      t_vld = 3'b000;
      t_lock = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("rst_mem_en d%0d", k), 32'(g_men[k]), 32'd0);
         chk($sformatf("rst_rd_vld d%0d", k), 32'(g_rdv[k]), 32'd0);
      end
      m_ptr = 0;
      p_en = 1'b0;
      m_last_gnt = 3'b000;
      for (int i = 0; i < 256; i++) m_mem[i] = '0;
      for (int k = 0; k < NDUT; k++) exp_q[k].delete();
      @(negedge clk);
      cyc++;
      check_regs();
      rst = 1'b0;
   endtask

   // Random traffic: granted requests retire, idle requesters may raise new ones
   task automatic rand_stim();
      for (int r = 0; r < 3; r++) begin
         if (m_last_gnt[r]) t_vld[r] = 1'b0;
         if (!t_vld[r] && $urandom_range(0, 3) != 0) begin
            t_vld[r]   = 1'b1;
            t_addr[r]  = addr_t'($urandom_range(0, 15));
            t_wdata[r] = w_t'($urandom);
            t_wen[r]   = (r == 0) ? 1'b1 : ((r == 2) ? 1'b0 : 1'($urandom_range(0, 1)));
         end
      end
      if ($urandom_range(0, 15) == 0) t_lock = ~t_lock;
   endtask

   initial begin
      int acc;
      n_cmp = 0; n_err = 0; cyc = 0; m_ptr = 0;
      t_vld = 3'b000; t_wen = 3'b000; t_addr = '0; t_wdata = '0; t_lock = 1'b0;
      m_last_gnt = 3'b000; obs_gnt = 3'b000;
      p_en = 1'b0; p_wen = 1'b0; p_addr = '0; p_wdata = '0;
      rst = 1'b1;
      @(negedge clk);
      do_reset();

      // ENQ writes 0xAA to addr 5, SORT reads it back the next cycle
      t_vld = 3'b001; t_wen = 3'b001; t_addr[0] = 8'd5; t_wdata[0] = 16'h00AA;
      cycle();
      t_vld = 3'b010; t_addr[1] = 8'd5;
      acc = cyc;
      cycle();
      chk("raw_sort_gnt", 32'(obs_gnt), 32'h2);
      t_vld = 3'b000;
      while (cyc < acc + 4) cycle();
      chk("raw_rd_vld", 32'(g_rdv[1]), 32'h2);
      chk("raw_rd_data", 32'(g_rdd[1]), 32'h00AA);

      // Round robin with all three requesting continuously
      do_reset();
      t_wen = 3'b011;
      for (int i = 0; i < 6; i++) begin
         t_vld = 3'b111; t_addr = {8'd20, 8'd21, 8'd22}; t_wdata[1] = w_t'(16'h5000 + i);
         cycle();
         chk("rr_seq", 32'(obs_gnt), 32'(3'b001 << (i % 3)));
         chk("rr_mem_en", 32'(g_men[0]), 32'd1);
      end

      // Lock after a SORT grant: only SORT served, DEQ first on release
      cycle();
      cycle();
      chk("pre_lock_sort", 32'(obs_gnt), 32'h2);
      t_lock = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("lock_sort_only", 32'(obs_gnt), 32'h2);
      end
      t_lock = 1'b0;
      cycle();
      chk("unlock_deq", 32'(obs_gnt), 32'h4);

      // Fill addr 0..7, then back-to-back DEQ reads
      t_vld = 3'b001; t_wen = 3'b001;
      for (int i = 0; i < 8; i++) begin
         t_addr[0] = addr_t'(i); t_wdata[0] = w_t'(16'h1000 + i);
         cycle();
      end
      for (int i = 0; i < 12; i++) begin
         if (i < 8) begin
            t_vld = 3'b100; t_addr[2] = addr_t'(i);
         end else begin
            t_vld = 3'b000;
         end
         cycle();
         if (i == 2) chk("b2b_not_early", 32'(g_rdv[1]), 32'd0);
         if (i >= 3 && i < 11) begin
            chk("b2b_rd_vld", 32'(g_rdv[1]), 32'h4);
            chk("b2b_rd_data", 32'(g_rdd[1]), 32'(16'h1000 + i - 3));
         end
      end

      // Reset with two reads in flight: nothing returns afterwards
      t_vld = 3'b100; t_addr[2] = 8'd3;
      cycle();
      t_addr[2] = 8'd4;
      cycle();
      do_reset();
      for (int i = 0; i < 6; i++) cycle();
      t_vld = 3'b111; t_wen = 3'b001;
      cycle();
      chk("post_rst_enq", 32'(obs_gnt), 32'h1);
      t_vld = 3'b000;
      cycle();

      // Random traffic across all three latencies
      for (int n = 0; n < 3000; n++) begin
         rand_stim();
         cycle();
      end

      t_vld = 3'b000; t_lock = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      for (int k = 0; k < NDUT; k++) chk($sformatf("drain d%0d", k), 32'(exp_q[k].size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/qs_mem_arb.md
# qs_mem_arb

Per-bank memory port arbiter for the quicksort engine. It shares the single-port bank SRAM between three requesters: enqueue (writes), sort (reads and writes) and dequeue (reads). It grants one request per cycle using round-robin, with a sort-engine lock for atomic read-modify-write (swap) sequences. It issues registered SRAM commands and routes read data back to the originating requester through a tag pipeline. One instance sits between each bank's SRAM macro and the enq/sort/deq engines.

## Interface
Parameters:
- RD_LAT, 1, SRAM read latency in cycles from mem_en_r to mem_rdata valid; legal range 1..4.

Ports (requester index r ∈ {0=ENQ, 1=SORT, 2=DEQ}; widths from qs_pkg):
- Clock and reset: single clock `clk`; reset `rst`, asynchronous, active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_vld  in  3  request valid per requester; must hold until granted.
- req_wen  in  3  per-requester write enable (1 = write, 0 = read); ENQ always writes, DEQ always reads.
- req_addr  in  3×addr_t  per-requester address.
- req_wdata  in  3×w_t  per-requester write data.
- req_gnt  out  3  one-hot grant, combinational, same cycle as acceptance.
- sort_lock  in  1  while high, grants go only to SORT.
- mem_en_r  out  1  SRAM access enable.
- mem_wen_r  out  1  SRAM write enable.
- mem_addr_r  out  addr_t  SRAM address.
- mem_wdata_r  out  w_t  SRAM write data.
- mem_rdata  in  w_t  SRAM read data, valid RD_LAT cycles after mem_en_r & ~mem_wen_r.
- rd_vld_r  out  3  one-hot read-return valid per requester.
- rd_data_r  out  w_t  read-return data, shared by all requesters.

## Operation
- A request is accepted when req_vld[r] & req_gnt[r]. At most one grant per cycle.
- Round-robin: a priority pointer rr_ptr (2 bits, values 0..2) marks the highest-priority requester. Search order is rr_ptr, rr_ptr+1, rr_ptr+2, modulo 3.
- After a grant to r, rr_ptr becomes (r+1) mod 3. With no grant, rr_ptr holds.
- Lock: when sort_lock=1, req_gnt = {0, req_vld[1], 0} and rr_ptr does not update. Asserting the lock takes effect in the same cycle, so a grant in a lock-assertion cycle can only go to SORT.
- Deasserting sort_lock restores round-robin in that cycle from the held rr_ptr.
- Accepted request is registered onto mem_*_r in the next cycle. mem_en_r is 1 for exactly one cycle per accepted request.
- Read tagging: each accepted read pushes a one-hot tag through a shift pipe of depth RD_LAT+1. Writes push a zero tag.
- rd_vld_r = tag at the pipe output. rd_data_r registers mem_rdata, enabled only when a valid read tag is at the matching stage.
- Writes generate no response. Same-address ordering follows grant order. A read granted one cycle after a write to the same address returns the new data.
- Illegal request types are not checked: ENQ read or DEQ write is passed through as-is.

## Timing
- Reset values: mem_en_r=0, mem_wen_r=0, rd_vld_r=0, rr_ptr=0 (ENQ first), all tag pipe stages 0.
- Data registers are not reset: mem_addr_r, mem_wdata_r, rd_data_r are meaningful only when qualified by their valid.
- Read latency: accepted at cycle T, mem_en_r at T+1, mem_rdata at T+1+RD_LAT, rd_vld_r/rd_data_r at T+2+RD_LAT. Total latency RD_LAT+2.
- Throughput: one access per cycle, back-to-back, any mix of reads and writes. Returns arrive in grant order.
- Reset mid-operation: all in-flight reads are dropped (no rd_vld_r). Requesters must reissue after reset.
- req_gnt depends only on req_vld, sort_lock and rr_ptr, never on req_wen, req_addr or req_wdata.

## Structure
- qs_pkg gains: `req_id_t` (enum ENQ=0, SORT=1, DEQ=2), `N_MEM_REQ=3`, and `mem_req_t` struct {wen, addr, wdata}.
- One sub-module, qs_rr_arb3: 3-way round-robin arbiter with hold (lock) input, plus rr_ptr register.
- Command register and tag pipe live in qs_mem_arb.

## Test plan
- Reset, then ENQ writes addr 5 = 0xAA; SORT reads addr 5 one cycle later -> rd_vld_r=3'b010 with rd_data_r=0xAA at acceptance+RD_LAT+2.
- All three req_vld held high for 6 cycles, no lock -> grants ENQ, SORT, DEQ, ENQ, SORT, DEQ; mem_en_r high for 6 consecutive cycles.
- sort_lock high for 4 cycles with ENQ and DEQ also requesting -> only SORT granted. After release, DEQ is granted if rr_ptr=2 (last grant before lock was SORT).
- Back-to-back DEQ reads of addr 0..7 with RD_LAT=2 -> rd_vld_r[2] high 8 consecutive cycles, data in address order, first at cycle T+4.
- Assert rst while two reads are in flight -> rd_vld_r stays 0; mem_en_r=0 and rr_ptr=0 immediately.
- Sweep RD_LAT=1 and RD_LAT=4 with random traffic -> scoreboard model: every accepted read returns exactly once with the correct tag and data.
